// File: rtl/ahb_mtx_out_arb_n.sv
// Output-stage arbiter for one shared AHB slave port: picks which input stage owns the
// address phase, holding the grant across fixed-length bursts, locked sequences and protected INCR bursts.
module ahb_mtx_out_arb_n #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2,
  parameter int ARB_MODE  = 0,
  parameter int INCR_HOLD = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic [NUM_PORTS-1:0] grant_onehot,
  output logic                 no_port
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [3:0] INCR_CNT  = (INCR_HOLD > 1) ? 4'(INCR_HOLD - 1) : 4'd0;

  logic [3:0]           cnt_q, cnt_d;
  logic                 hold_q, hold_d;
  logic [PORT_W-1:0]    addr_q, addr_d;
  logic                 no_port_q, no_port_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PORT_W-1:0]    rr_last_q, rr_last_d;
  logic [NUM_PORTS-1:0] cand;
  logic                 active;
  logic                 sel_found;
  logic [PORT_W-1:0]    sel_idx;
  int                   scan_idx;

  assign active = HSELM && (HTRANSM != TR_IDLE);

  // The current owner stays a candidate while its transfer is live, even if its request dropped.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign cand[gi]    = req_port[gi] | (active & (addr_q == PORT_W'(gi)));
    assign grant_d[gi] = ~no_port_d & (addr_d == PORT_W'(gi));
  end

  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (HREADYM) begin
      if (!HSELM) begin
        cnt_d  = 4'd0;
        hold_d = 1'b0;
      end else begin
        case (HTRANSM)
          TR_IDLE: begin
            cnt_d  = 4'd0;
            hold_d = 1'b0;
          end
          TR_BUSY: ;
          TR_NONSEQ: begin
            case (HBURSTM)
              3'b110, 3'b111: begin cnt_d = 4'd15; hold_d = 1'b1; end
              3'b100, 3'b101: begin cnt_d = 4'd7;  hold_d = 1'b1; end
              3'b010, 3'b011: begin cnt_d = 4'd3;  hold_d = 1'b1; end
              3'b001: begin
                cnt_d  = INCR_CNT;
                hold_d = (INCR_HOLD > 1);
              end
              default: begin cnt_d = 4'd0; hold_d = 1'b0; end
            endcase
          end
          TR_SEQ: begin
            if (cnt_q == 4'd0) begin
              hold_d = 1'b0;
            end else begin
              cnt_d = cnt_q - 4'd1;
              if (cnt_q == 4'd1) hold_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = 0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (cand[i]) begin
          sel_found = 1'b1;
          sel_idx   = PORT_W'(i);
        end
      end
    end else begin
      // Scan starts just past the last winner and wraps, so every requester is reached in turn.
      for (int k = 0; k < NUM_PORTS; k++) begin
        scan_idx = int'(rr_last_q) + 1 + k;
        if (scan_idx >= NUM_PORTS) scan_idx = scan_idx - NUM_PORTS;
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (!sel_found && cand[i] && (scan_idx == i)) begin
            sel_found = 1'b1;
            sel_idx   = PORT_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    addr_d    = addr_q;
    no_port_d = no_port_q;
    rr_last_d = rr_last_q;
    if (HREADYM) begin
      if (HMASTLOCKM || hold_d) begin
        no_port_d = 1'b0;
      end else if (sel_found) begin
        addr_d    = sel_idx;
        no_port_d = 1'b0;
      end else if (HSELM) begin
        no_port_d = 1'b0;
      end else begin
        no_port_d = 1'b1;
      end
      if (!no_port_d && ((addr_d != addr_q) || no_port_q)) rr_last_d = addr_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt_q     <= 4'd0;
      hold_q    <= 1'b0;
      addr_q    <= '0;
      no_port_q <= 1'b1;
      grant_q   <= '0;
      rr_last_q <= PORT_W'(NUM_PORTS - 1);
    end else if (HREADYM) begin
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      addr_q    <= addr_d;
      no_port_q <= no_port_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign addr_in_port = addr_q;
  assign grant_onehot = grant_q;
  assign no_port      = no_port_q;

endmodule
